// File: rtl/fetch_predict_unit_if.sv
// Signal bundle between the fetch/predict stage and its memory, dispatch and ROB neighbours.
// The master modport is the fetch stage; the slave modport is its environment.
interface fetch_predict_unit_if;
    logic        rdy_in;
    logic        fetch_req_out;
    logic [31:0] fetch_pc_out;
    logic        fetch_done_in;
    logic [31:0] fetch_ins_in;
    logic        rob_full_in;
    logic        rs_full_in;
    logic        lsb_full_in;
    logic        ins_to_rob_out;
    logic        ins_to_rs_out;
    logic        ins_to_lsb_out;
    logic [31:0] disp_ins_out;
    logic [31:0] disp_pc_out;
    logic        disp_pred_out;
    logic        rob_commit_in;
    logic        rob_is_branch_in;
    logic [31:0] rob_pc_in;
    logic        rob_taken_in;
    logic        rob_redirect_in;
    logic [31:0] rob_target_in;
    logic        roll_back_out;

    modport master (
        input  rdy_in, fetch_done_in, fetch_ins_in, rob_full_in, rs_full_in, lsb_full_in,
               rob_commit_in, rob_is_branch_in, rob_pc_in, rob_taken_in, rob_redirect_in,
               rob_target_in,
        output fetch_req_out, fetch_pc_out, ins_to_rob_out, ins_to_rs_out, ins_to_lsb_out,
               disp_ins_out, disp_pc_out, disp_pred_out, roll_back_out
    );

    modport slave (
        output rdy_in, fetch_done_in, fetch_ins_in, rob_full_in, rs_full_in, lsb_full_in,
               rob_commit_in, rob_is_branch_in, rob_pc_in, rob_taken_in, rob_redirect_in,
               rob_target_in,
        input  fetch_req_out, fetch_pc_out, ins_to_rob_out, ins_to_rs_out, ins_to_lsb_out,
               disp_ins_out, disp_pc_out, disp_pred_out, roll_back_out
    );
endinterface

// File: rtl/fetch_predict_unit.sv
// Fetch stage: PC generation, fetch handshake, pre-decode with a 2-bit BHT, instruction queue
// and single-issue dispatch to ROB plus RS or LSB; flushed and redirected by ROB commit.
module fetch_predict_unit #(
    parameter int          DEPTH       = 16,
    parameter int          BHT_ENTRIES = 64,
    parameter logic [31:0] RESET_PC    = 32'h0
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    fetch_predict_unit_if.master bus
);
    localparam int          PW        = $clog2(DEPTH);
    localparam int          BW        = $clog2(BHT_ENTRIES);
    localparam logic [PW:0] DEPTH_CNT = (PW+1)'(DEPTH);

    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_ST   = 7'b0100011;

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DRAIN = 2'd2} state_t;
    state_t state_reg, state_next;

    logic [31:0]   pc_reg;
    logic          halt_reg;
    logic [PW-1:0] head_reg, tail_reg;
    logic [PW:0]   count_reg;
    logic          roll_back_reg;
    logic          fetch_req;

    logic [31:0] q_ins  [DEPTH];
    logic [31:0] q_pc   [DEPTH];
    logic        q_pred [DEPTH];
    logic [1:0]  bht_reg  [BHT_ENTRIES];
    logic [1:0]  bht_next [BHT_ENTRIES];

    logic          redirect_req, redirect, done, push, pop, empty;
    logic [31:0]   ins, imm_j, imm_b, pc_next;
    logic          pred_bit, is_jalr;
    logic [1:0]    bht_ctr;
    logic [6:0]    head_op;
    logic          head_ls, target_full;
    logic          bht_upd;
    logic [BW-1:0] upd_idx;
    logic [1:0]    upd_old, upd_new;
    logic          unused_pc_bits;

    assign redirect_req = bus.rob_commit_in & bus.rob_redirect_in;
    assign redirect     = bus.rdy_in & redirect_req;
    assign done         = bus.rdy_in & bus.fetch_done_in;
    assign push         = (state_reg == WAIT) & done & ~redirect_req;
    assign empty        = (count_reg == '0);

    // Pre-decode of the returning word; the BHT read sees the pre-update counter value.
    assign ins     = bus.fetch_ins_in;
    assign imm_j   = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
    assign imm_b   = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
    assign bht_ctr = bht_reg[pc_reg[BW+1:2]];

    always_comb begin
        pc_next  = pc_reg + 32'd4;
        pred_bit = 1'b0;
        is_jalr  = 1'b0;
        case (ins[6:0])
            OP_JAL: begin
                pc_next  = pc_reg + imm_j;
                pred_bit = 1'b1;
            end
            OP_BR: begin
                pred_bit = bht_ctr[1];
                if (bht_ctr[1]) pc_next = pc_reg + imm_b;
            end
            OP_JALR: is_jalr = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) state_reg <= IDLE;
        else if (bus.rdy_in) state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (!redirect && !halt_reg && count_reg < DEPTH_CNT) state_next = WAIT;
            WAIT:    if (redirect) state_next = done ? IDLE : DRAIN;
                     else if (done) state_next = IDLE;
            DRAIN:   if (done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        fetch_req = 1'b0;
        if (state_reg == WAIT) fetch_req = 1'b1;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            pc_reg        <= RESET_PC;
            halt_reg      <= 1'b0;
            head_reg      <= '0;
            tail_reg      <= '0;
            count_reg     <= '0;
            roll_back_reg <= 1'b0;
        end else if (bus.rdy_in) begin
            roll_back_reg <= redirect;
            if (redirect) begin
                pc_reg    <= bus.rob_target_in;
                halt_reg  <= 1'b0;
                head_reg  <= '0;
                tail_reg  <= '0;
                count_reg <= '0;
            end else begin
                if (push) begin
                    tail_reg <= tail_reg + 1'b1;
                    pc_reg   <= pc_next;
                    if (is_jalr) halt_reg <= 1'b1;
                end
                if (pop) head_reg <= head_reg + 1'b1;
                if (push && !pop) count_reg <= count_reg + 1'b1;
                else if (!push && pop) count_reg <= count_reg - 1'b1;
            end
        end else begin
            roll_back_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (push) begin
            q_ins[tail_reg]  <= ins;
            q_pc[tail_reg]   <= pc_reg;
            q_pred[tail_reg] <= pred_bit;
        end
    end

    assign bht_upd = bus.rob_commit_in & bus.rob_is_branch_in;
    assign upd_idx = bus.rob_pc_in[BW+1:2];
    assign upd_old = bht_reg[upd_idx];
    assign unused_pc_bits = ^{bus.rob_pc_in[31:BW+2], bus.rob_pc_in[1:0]};

    always_comb begin
        upd_new = upd_old;
        if (bus.rob_taken_in) begin
            if (upd_old != 2'b11) upd_new = upd_old + 2'd1;
        end else if (upd_old != 2'b00) begin
            upd_new = upd_old - 2'd1;
        end
    end

    generate
        for (genvar gi = 0; gi < BHT_ENTRIES; gi++) begin : g_bht
            assign bht_next[gi] = (bht_upd && upd_idx == BW'(gi)) ? upd_new : bht_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < BHT_ENTRIES; i++) bht_reg[i] <= 2'b01;
        end else if (bus.rdy_in) begin
            for (int i = 0; i < BHT_ENTRIES; i++) bht_reg[i] <= bht_next[i];
        end
    end

    // Dispatch is purely combinational from the head slot; no bypass of a stalled head.
    assign head_op     = q_ins[head_reg][6:0];
    assign head_ls     = (head_op == OP_LD) || (head_op == OP_ST);
    assign target_full = head_ls ? bus.lsb_full_in : bus.rs_full_in;
    assign pop         = bus.rdy_in & ~empty & ~bus.rob_full_in & ~target_full & ~redirect_req;

    assign bus.fetch_req_out  = fetch_req;
    assign bus.fetch_pc_out   = pc_reg;
    assign bus.ins_to_rob_out = pop;
    assign bus.ins_to_rs_out  = pop & ~head_ls;
    assign bus.ins_to_lsb_out = pop & head_ls;
    assign bus.disp_ins_out   = empty ? 32'h0 : q_ins[head_reg];
    assign bus.disp_pc_out    = empty ? 32'h0 : q_pc[head_reg];
    assign bus.disp_pred_out  = empty ? 1'b0 : q_pred[head_reg];
    assign bus.roll_back_out  = roll_back_reg;
endmodule
